// File: rtl/axi_slv_mem_pkg.sv
// Shared types and constants for the AXI4 slave memory: burst encodings,
// response codes and the write/read state machine encodings.
package axi_slv_mem_pkg;

  // AXI burst types; 2'b11 is reserved and behaves like INCR
  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // Requested beat sizes wider than the data bus collapse to the bus width
  function automatic logic [2:0] clamp_size(input logic [2:0] size,
                                            input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi_slv_mem_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for one AXI burst.
// FIXED holds the address, INCR and reserved step by the beat size from the
// size-aligned address, WRAP wraps inside a (len+1)*2^size aligned window
// when len is 1, 3, 7 or 15 and otherwise falls back to INCR.
module axi_burst_addr_gen
  import axi_slv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  // Compute the step, the wrap window and select by burst type
  always_comb begin
    beat_bytes = ADDR_WIDTH'(1) << size;
    aligned    = addr & ~(beat_bytes - ADDR_WIDTH'(1));
    incr_addr  = aligned + beat_bytes;
    wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wrap_mask  = wrap_bytes - ADDR_WIDTH'(1);
    wrap_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr  = incr_addr;
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                   : incr_addr;
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_slv_mem.sv
// axi_slv_mem: AXI4 slave backed by an internal word array, with independent
// write (AW/W/B) and read (AR/R) state machines. All outputs are registered.
// Build option AXI_SLV_MEM_RANGE_CHK_EN: beats whose word index is beyond
// MEM_DEPTH are dropped/zeroed and answered with SLVERR; without it the word
// index simply wraps modulo MEM_DEPTH.
module axi_slv_mem
  import axi_slv_mem_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam int         OFFS     = $clog2(STRB_W);
  localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(OFFS);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Write-side state
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next_addr;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs, w_hs, b_hs, w_oor, mem_we;
  logic [IDX_W-1:0]      w_idx;

  // Read-side state
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next_addr, rd_addr;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs, r_hs, rd_oor;
  logic [IDX_W-1:0]      rd_idx;

  // The write data channel id carries no meaning for this slave
  logic unused_wid;
  assign unused_wid = ^wid;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFFS;
    return IDX_W'(w % ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;
  assign b_hs  = bready & bvalid_q;
  assign ar_hs = arvalid & arready_q;
  assign r_hs  = rready & rvalid_q;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr_gen (
    .addr      (w_addr_q),
    .size      (w_size_q),
    .len       (w_len_q),
    .burst     (w_burst_q),
    .next_addr (w_next_addr)
  );

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_addr_gen (
    .addr      (r_addr_q),
    .size      (r_size_q),
    .len       (r_len_q),
    .burst     (r_burst_q),
    .next_addr (r_next_addr)
  );

  // A new AR prefetches from araddr; otherwise the prefetch follows the burst
  assign rd_addr = ar_hs ? araddr : r_next_addr;
  assign w_idx   = word_idx(w_addr_q);
  assign rd_idx  = word_idx(rd_addr);

  // Flag beats that fall outside the array (only when range checking is built in)
  always_comb begin
`ifdef AXI_SLV_MEM_RANGE_CHK_EN
    w_oor  = (w_addr_q >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH);
    rd_oor = (rd_addr >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH);
`else
    w_oor  = 1'b0;
    rd_oor = 1'b0;
`endif
  end

  // Prefetch word read before this edge's write lands, so a collision sees old data
  always_comb begin
    rd_word = rd_oor ? '0 : mem_q[rd_idx];
  end

  // Byte-lane write into the array; contents deliberately survive reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Write FSM state register together with its burst context and output flops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write FSM next state: the burst ends after len+1 beats regardless of wlast
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write burst context, error accumulation, memory enable and next outputs
  always_comb begin
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    if (aw_hs) begin
      w_id_d    = awid;
      w_addr_d  = awaddr;
      w_len_d   = awlen;
      w_cnt_d   = '0;
      w_size_d  = clamp_size(awsize, MAX_SIZE);
      w_burst_d = awburst;
      w_err_d   = 1'b0;
    end else if (w_hs) begin
      mem_we   = ~w_oor;
      w_addr_d = w_next_addr;
      w_cnt_d  = w_cnt_q + 8'd1;
      w_err_d  = w_err_q | w_oor | (wlast != (w_cnt_q == w_len_q));
    end
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bid_d     = bvalid_d ? w_id_d : '0;
    bresp_d   = (bvalid_d && w_err_d) ? SLVERR : OKAY;
  end

  // Read FSM state register together with its burst context and output flops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read FSM next state: leave R_DATA on the handshake of the last beat
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read burst context and prefetch of the beat presented after each handshake
  always_comb begin
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    if (ar_hs) begin
      r_id_d    = arid;
      r_addr_d  = araddr;
      r_len_d   = arlen;
      r_cnt_d   = '0;
      r_size_d  = clamp_size(arsize, MAX_SIZE);
      r_burst_d = arburst;
      rdata_d   = rd_word;
      rresp_d   = rd_oor ? SLVERR : OKAY;
      rlast_d   = (arlen == 8'd0);
    end else if (r_hs) begin
      if (rlast_q) begin
        rdata_d = '0;
        rresp_d = OKAY;
        rlast_d = 1'b0;
      end else begin
        r_addr_d = r_next_addr;
        r_cnt_d  = r_cnt_q + 8'd1;
        rdata_d  = rd_word;
        rresp_d  = rd_oor ? SLVERR : OKAY;
        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
      end
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rid_d     = rvalid_d ? r_id_d : '0;
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Testbench for axi_slv_mem: directed scenarios plus randomized bursts checked
// against a byte-array memory model and closed-form AXI beat addresses.
// Honours AXI_SLV_MEM_RANGE_CHK_EN when the design is built with it.
module tb_axi_slv_mem;
  import axi_slv_mem_pkg::*;

  localparam int ID_W  = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int TMO   = 64;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [ID_W-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  logic [31:0] rd_obs [16];
  logic [1:0]  rd_resp_obs [16];
  logic [1:0]  last_bresp;

  always #5 aclk = ~aclk;

  axi_slv_mem #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // Advance one clock and settle past the edge before sampling or driving
  task automatic applyStimulus();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i per the AXI burst rules
  function automatic logic [31:0] beatAddr(input logic [31:0] start, input int len,
                                           input int size, input int burst, input int i);
    int unsigned nb, wsz, lower, aligned;
    nb = 1 << ((size > 2) ? 2 : size);
    aligned = (start / nb) * nb;
    if (burst == 0 || i == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wsz   = (len + 1) * nb;
      lower = (start / wsz) * wsz;
      return lower + ((aligned - lower + i * nb) % wsz);
    end
    return aligned + i * nb;
  endfunction

  function automatic bit modelOor(input logic [31:0] a);
`ifdef AXI_SLV_MEM_RANGE_CHK_EN
    return (a / 4) >= DEPTH;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int modelIdx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic setBeats(input int len, input logic [31:0] base, input logic [3:0] strb);
    for (int i = 0; i < 16; i++) begin
      wd[i] = base + i;
      ws[i] = strb;
      wl[i] = (i == len);
    end
  endtask

  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input bit rnd);
    int cyc;
    int n;
    bit exp_err;
    logic [31:0] a;
    int idx;
    exp_err = 1'b0;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    cyc = 0;
    while (awready !== 1'b1 && cyc < TMO) begin applyStimulus(); cyc++; end
    checkOutput("aw_wait", 64'(cyc < TMO), 64'd1);
    applyStimulus();
    awvalid = 1'b0;
    checkOutput("aw_accept", {awready, wready}, 2'b01);
    for (int i = 0; i <= len; i++) begin
      if (rnd) begin
        wvalid = 1'b0;
        n = $urandom_range(0, 2);
        repeat (n) applyStimulus();
      end
      wid = id; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      cyc = 0;
      while (wready !== 1'b1 && cyc < TMO) begin applyStimulus(); cyc++; end
      checkOutput("w_wait", 64'(cyc < TMO), 64'd1);
      a = beatAddr(addr, len, size, burst, i);
      if (wl[i] != (i == len)) exp_err = 1'b1;
      if (modelOor(a)) exp_err = 1'b1;
      else begin
        idx = modelIdx(a);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
      end
      applyStimulus();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    checkOutput("w_done", {wready, bvalid}, 2'b01);
    if (rnd) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        applyStimulus();
        checkOutput("b_hold", {bvalid, bresp}, {1'b1, exp_err ? SLVERR : OKAY});
      end
    end
    bready = 1'b1;
    checkOutput("bresp", bresp, exp_err ? SLVERR : OKAY);
    checkOutput("bid", bid, id);
    last_bresp = bresp;
    applyStimulus();
    bready = 1'b0;
    checkOutput("b_done", {bvalid, awready}, 2'b01);
  endtask

  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input bit rnd);
    int cyc;
    int n;
    logic [31:0] a;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0;
    while (arready !== 1'b1 && cyc < TMO) begin applyStimulus(); cyc++; end
    checkOutput("ar_wait", 64'(cyc < TMO), 64'd1);
    applyStimulus();
    arvalid = 1'b0;
    checkOutput("ar_accept", {arready, rvalid}, 2'b01);
    for (int i = 0; i <= len; i++) begin
      a = beatAddr(addr, len, size, burst, i);
      exp_data = modelOor(a) ? 32'h0 : model_mem[modelIdx(a)];
      exp_resp = modelOor(a) ? SLVERR : OKAY;
      if (rnd) begin
        rready = 1'b0;
        n = $urandom_range(0, 2);
        repeat (n) begin
          applyStimulus();
          checkOutput("r_hold", {rvalid, rdata}, {1'b1, exp_data});
        end
      end
      rready = 1'b1;
      checkOutput("rvalid", rvalid, 1'b1);
      checkOutput("rdata", rdata, exp_data);
      checkOutput("rlast", rlast, (i == len));
      checkOutput("rresp", rresp, exp_resp);
      checkOutput("rid", rid, id);
      rd_obs[i] = rdata;
      rd_resp_obs[i] = rresp;
      applyStimulus();
    end
    rready = 1'b0;
    checkOutput("r_done", {rvalid, arready}, 2'b01);
  endtask

  // Hard stop in case a wait somewhere is not bounded as intended
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized write/read traffic
  initial begin
    int len, rlen;
    logic [2:0] sz;
    logic [1:0] bt;
    logic [31:0] ad;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    last_bresp = '0;

    repeat (3) applyStimulus();
    checkOutput("reset_outs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rid,
                               rdata, rresp, rlast}, 64'd0);
    aresetn = 1'b1;
    checkOutput("pre_edge_ready", {awready, arready}, 2'b00);
    applyStimulus();
    checkOutput("post_reset_ready", {awready, arready, wready, bvalid, rvalid}, 5'b11000);

    $display("[TB] initialising words 0..63");
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'hF;
        wl[i] = (i == 15);
      end
      writeBurst(4'(k), 32'(k * 64), 15, 3'd2, INCR, 1'b0);
    end

    $display("[TB] INCR burst write/read");
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; wl[i] = (i == 3); end
    writeBurst(4'h1, 32'h10, 3, 3'd2, INCR, 1'b0);
    checkOutput("incr_bresp", last_bresp, OKAY);
    readBurst(4'h2, 32'h10, 3, 3'd2, INCR, 1'b0);
    checkOutput("incr_b0", rd_obs[0], 32'hA0);
    checkOutput("incr_b1", rd_obs[1], 32'hA1);
    checkOutput("incr_b2", rd_obs[2], 32'hA2);
    checkOutput("incr_b3", rd_obs[3], 32'hA3);

    $display("[TB] WRAP burst write, INCR read");
    setBeats(3, 32'hB0, 4'hF);
    writeBurst(4'h3, 32'h18, 3, 3'd2, WRAP, 1'b0);
    readBurst(4'h4, 32'h10, 3, 3'd2, INCR, 1'b0);
    checkOutput("wrap_0x10", rd_obs[0], 32'hB2);
    checkOutput("wrap_0x14", rd_obs[1], 32'hB3);
    checkOutput("wrap_0x18", rd_obs[2], 32'hB0);
    checkOutput("wrap_0x1C", rd_obs[3], 32'hB1);

    $display("[TB] byte strobes");
    setBeats(0, 32'h1234_5678, 4'hF);
    writeBurst(4'h5, 32'h40, 0, 3'd2, INCR, 1'b0);
    setBeats(0, 32'hFFFF_FFFF, 4'b0101);
    writeBurst(4'h5, 32'h40, 0, 3'd2, INCR, 1'b0);
    readBurst(4'h6, 32'h40, 0, 3'd2, INCR, 1'b0);
    checkOutput("strb_merge", rd_obs[0], 32'h12FF_56FF);

    $display("[TB] wlast mismatches");
    setBeats(3, 32'hC0, 4'hF);
    wl[1] = 1'b1;
    wl[3] = 1'b0;
    writeBurst(4'h7, 32'h80, 3, 3'd2, INCR, 1'b0);
    checkOutput("early_wlast_bresp", last_bresp, SLVERR);
    setBeats(1, 32'hD0, 4'hF);
    wl[1] = 1'b0;
    writeBurst(4'h8, 32'h90, 1, 3'd2, INCR, 1'b0);
    checkOutput("missing_wlast_bresp", last_bresp, SLVERR);
    readBurst(4'h9, 32'h80, 3, 3'd2, INCR, 1'b0);
    checkOutput("early_wlast_data3", rd_obs[3], 32'hC3);

    $display("[TB] out-of-depth address");
    setBeats(0, 32'hDEAD_BEEF, 4'hF);
    writeBurst(4'hA, 32'(DEPTH * 4), 0, 3'd2, INCR, 1'b0);
`ifdef AXI_SLV_MEM_RANGE_CHK_EN
    checkOutput("oor_bresp", last_bresp, SLVERR);
    readBurst(4'hB, 32'(DEPTH * 4), 0, 3'd2, INCR, 1'b0);
    checkOutput("oor_rdata", rd_obs[0], 32'h0);
    checkOutput("oor_rresp", rd_resp_obs[0], SLVERR);
    readBurst(4'hB, 32'h0, 0, 3'd2, INCR, 1'b0);
`else
    checkOutput("alias_bresp", last_bresp, OKAY);
    readBurst(4'hB, 32'h0, 0, 3'd2, INCR, 1'b0);
    checkOutput("alias_word0", rd_obs[0], 32'hDEAD_BEEF);
`endif

    $display("[TB] reset during a read burst");
    arid = 4'hC; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
    applyStimulus();
    arvalid = 1'b0;
    rready = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_beat2_valid", {rvalid, rlast}, 2'b10);
    aresetn = 1'b0;
    #1;
    checkOutput("rst_outs_zero", {rvalid, arready, awready, rdata, rlast}, 64'd0);
    rready = 1'b0;
    applyStimulus();
    aresetn = 1'b1;
    applyStimulus();
    checkOutput("rst_arready_back", {arready, rvalid}, 2'b10);
    readBurst(4'hD, 32'h10, 3, 3'd2, INCR, 1'b0);

    $display("[TB] randomized bursts");
    for (int t = 0; t < 16; t++) begin
      len = $urandom_range(0, 7);
      sz  = 3'($urandom_range(0, 4));
      bt  = 2'($urandom_range(0, 3));
      ad  = 32'($urandom_range(0, 163));
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom_range(0, 15));
        wl[i] = (i == len) ^ ($urandom_range(0, 9) == 0);
      end
      writeBurst(4'($urandom_range(0, 15)), ad, len, sz, bt, 1'b1);
      rlen = $urandom_range(0, 7);
      readBurst(4'($urandom_range(0, 15)), 32'($urandom_range(0, 163)), rlen,
                3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/axi_slv_mem.md
# axi_slv_mem

Synthesizable AXI4 slave memory that terminates the slave side of the AXI link. It is the DUT-side endpoint that the slave agent's driver and monitor connect to through the slave interface. It accepts write address/data bursts, stores them in an internal word array, and returns write responses. It serves read bursts from the same array, with independent write and read state machines.

## Interface
- ID_WIDTH, 4, width of awid/wid/bid/arid/rid
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width (power of two, ≥ 8)
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words in the array
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address channel
- awready  out  1  write address ready
- wid/wdata/wstrb/wlast/wvalid  in  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel (wid ignored)
- wready  out  1  write data ready
- bid/bresp/bvalid  out  ID_WIDTH/2/1  write response channel
- bready  in  1  write response ready
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  read address channel
- arready  out  1  read address ready
- rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel
- rready  in  1  read data ready

## Operation
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE. W_IDLE: awready=1. An AW handshake latches id, addr, len, size, and burst, and clears the beat counter. W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb at the current word, advances the address, and increments the count. After beat len+1 the FSM moves to W_RESP. W_RESP: bvalid=1, bid=latched id. The FSM holds until bready.
- A wlast value that disagrees with the beat count (early or missing) sets the error flag, which gives bresp=SLVERR (2'b10). The burst still ends after exactly len+1 beats.
- Read FSM R_IDLE → R_DATA → R_IDLE. R_IDLE: arready=1. An AR handshake latches the request and loads beat 0 into rdata. R_DATA: rvalid=1, rid=latched id, rlast=1 on beat len. Each R handshake loads the next beat (prefetch from the next address). The last handshake returns the FSM to R_IDLE.
- Word index = addr >> log2(DATA_WIDTH/8).
- Size: awsize/arsize above log2(DATA_WIDTH/8) is clamped to that value.
- Address update per burst type:
  - FIXED (00): address held.
  - INCR (01) and reserved (11): next = (addr & ~(2^size−1)) + 2^size.
  - WRAP (10): wrap at boundary (len+1)·2^size, aligned. len is restricted to 1, 3, 7 or 15; any other len is treated as INCR.
- No 4 KB boundary check.
- Write and read FSMs are fully independent. A same-edge write and read-prefetch to one word returns the pre-write data.
- Memory contents are not reset.

## Timing
- Reset: all outputs 0, both FSMs in IDLE.
- All outputs are registered. awready and arready rise on the first aclk edge after aresetn deasserts.
- Write channel:
  - AW handshake at edge N → awready=0 and wready=1 from N+1.
  - Last W handshake at M → wready=0 and bvalid=1 from M+1.
  - B handshake at K → bvalid=0 and awready=1 from K+1.
  - Single-beat write occupies at least 3 cycles.
- Read channel:
  - AR handshake at N → rvalid=1 with beat 0 from N+1.
  - Back-to-back beats are allowed with rready held high, one beat per cycle.
  - Last R handshake at M → rvalid=0 and arready=1 from M+1.
- rvalid, rdata, rlast, bvalid, bresp, and bid are stable while valid is high and ready is low.
- aresetn assertion mid-burst: both FSMs return to IDLE immediately and all outputs go to 0. Partial writes already committed remain in memory.

## Configuration
- AXI_SLV_MEM_RANGE_CHK_EN defined:
  - Any beat whose word index is ≥ MEM_DEPTH is not written.
  - Such a beat forces bresp=SLVERR for the burst.
  - Reads of such a beat return rdata=0 with rresp=SLVERR for that beat.
- AXI_SLV_MEM_RANGE_CHK_EN undefined: the word index is taken modulo MEM_DEPTH and range errors never occur. bresp can still be SLVERR from a wlast mismatch; rresp is always OKAY.

## Structure
- Shared package axi_slv_mem_pkg holds:
  - burst type enum: FIXED, INCR, WRAP
  - response constants OKAY=2'b00 and SLVERR=2'b10
  - write and read FSM state enums
- One sub-module, axi_burst_addr_gen: a combinational next-address function of (addr, size, len, burst). It is instantiated once each by the write and read paths.

## Test plan
- AW addr=0x10, len=3, INCR, size=2, data 0xA0..0xA3, all wstrb=1 → bresp=OKAY. Read back the same burst → rdata 0xA0,0xA1,0xA2,0xA3, rlast on beat 3, rresp=OKAY.
- WRAP len=3, size=2, addr=0x18 write → words land at 0x18,0x1C,0x10,0x14. INCR read of 0x10 len=3 confirms the order.
- wstrb=4'b0101 writing 0xFFFFFFFF over 0x12345678 → readback 0x12FF56FF.
- wlast asserted on beat 1 of a len=3 burst → 4 beats accepted, bresp=SLVERR.
- With RANGE_CHK_EN, write addr = MEM_DEPTH·4 → bresp=SLVERR and no word changed. Read of the same address → rdata=0, rresp=SLVERR.
- aresetn pulsed during beat 2 of a read → rvalid=0 next cycle, arready=1 after release, and a new AR is accepted normally.
